// File: rtl/receptor_medida.sv
// receptor_medida: validates ASCII trena frames "ddd#" and latches the BCD measurement
module receptor_medida #(
   parameter int TIMEOUT_CICLOS = 50_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ligar,
   input  logic [7:0]  dado_recebido,
   input  logic        recebido,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado
);
   localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
   typedef enum logic [3:0] {
      st_inicial  = 4'h0,
      st_centena  = 4'h1,
      st_dezena   = 4'h2,
      st_unidade  = 4'h3,
      st_final    = 4'h4,
      st_armazena = 4'h5,
      st_fim      = 4'h6,
      st_erro     = 4'hE
   } estado_t;
   estado_t estado, proximo;
   logic [11:0] buffer;
   logic [CW-1:0] contador;
   logic digito, terminador, expirou, em_quadro;
   assign digito = dado_recebido[7:4] == 4'h3 && dado_recebido[3:0] <= 4'd9;
   assign terminador = dado_recebido == 8'h23;
   assign expirou = contador == CW'(TIMEOUT_CICLOS - 1);
   assign em_quadro = estado inside {st_dezena, st_unidade, st_final};
   always_comb begin
      proximo = st_inicial;
      case (estado)
         st_inicial:  proximo = st_centena;
         st_centena:  proximo = (recebido && digito) ? st_dezena : st_centena;
         st_dezena:   proximo = recebido ? (digito ? st_unidade : st_erro) : (expirou ? st_erro : st_dezena);
         st_unidade:  proximo = recebido ? (digito ? st_final : st_erro) : (expirou ? st_erro : st_unidade);
         st_final:    proximo = recebido ? (terminador ? st_armazena : st_erro) : (expirou ? st_erro : st_final);
         st_armazena: proximo = st_fim;
         st_fim:      proximo = st_centena;
         st_erro:     proximo = st_centena;
         default:     proximo = st_inicial;
      endcase
      if (!ligar) proximo = st_inicial;
   end
   // the counter only runs while the state holds inside a frame; any transition restarts it
   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= st_inicial;
         buffer   <= '0;
         medida   <= '0;
         contador <= '0;
      end else begin
         estado   <= proximo;
         contador <= (em_quadro && proximo == estado) ? contador + CW'(1) : '0;
         if (!ligar || estado == st_erro) buffer <= '0;
         else if (recebido && digito) begin
            if (estado == st_centena) buffer[11:8] <= dado_recebido[3:0];
            if (estado == st_dezena) buffer[7:4] <= dado_recebido[3:0];
            if (estado == st_unidade) buffer[3:0] <= dado_recebido[3:0];
         end
         if (estado == st_armazena) medida <= buffer;
      end
   end
   assign pronto = estado == st_fim;
   assign erro = estado == st_erro;
   assign db_estado = (estado inside {st_inicial, st_centena, st_dezena, st_unidade, st_final, st_armazena, st_fim, st_erro}) ? estado : 4'hF;
endmodule
